demux_1_4_collector: RTL and testbench

//  Downstream consumer of the 1:4 demux (demux_1_4). Samples the demux select and

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_1_4_collector_lane.sv | 55 +++++
 rtl/demux_1_4_collector.sv | 105 ++++++++++
 tb/tb_demux_1_4_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared channel definitions for the 1:4 demux collector.
package demux_pkg;

    localparam int CH_NUM = 4;

    // Channel index, encoded as {sel1, sel0}
    typedef logic [1:0] ch_t;

    function automatic ch_t ch_from_sel(input logic sel1, input logic sel0);
        return {sel1, sel0};
    endfunction

    function automatic logic [CH_NUM-1:0] ch_onehot(input ch_t ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/demux_1_4_collector_lane.sv
// One collector lane: assembles serial bits LSB-first into a word and keeps
// one completed word in a holding register until the arbiter drains it.
module collector_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smp,
    input  logic             bit_in,
    input  logic             drain,
    output logic [WIDTH-1:0] hold,
    output logic             hold_v,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             done;
    logic [WIDTH-1:0] word;

    // The completing bit always lands in the MSB, so the finished word is
    // formed directly from the incoming bit and the bits gathered so far.
    assign done = smp && (cnt == CW'(WIDTH - 1));
    assign word = {bit_in, shreg[WIDTH-2:0]};

    // Bit assembly, word hand-off to the holding register, overflow tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            shreg  <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (smp) begin
                shreg[cnt] <= bit_in;
                cnt        <= done ? '0 : cnt + 1'b1;
            end
            if (done) begin
                // A held word that is not leaving this edge wins; the new one is lost.
                if (hold_v && !drain) begin
                    ovf <= 1'b1;
                end else begin
                    hold   <= word;
                    hold_v <= 1'b1;
                end
            end else if (drain) begin
                hold_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_1_4_collector.sv
// Collector for the 1:4 demux: validates each strobe, feeds four assembly
// lanes, and round-robin arbitrates completed words onto one valid/ready port.
module demux_1_4_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic [3:0]       ovf,
    output logic             perr
);

    logic [CH_NUM-1:0] y_vec;
    ch_t               ch;
    logic              stray;
    logic              smp_ok;
    logic [CH_NUM-1:0] hold_v_vec;
    logic [WIDTH-1:0]  hold_w [CH_NUM];
    logic [CH_NUM-1:0] drain_vec;
    ch_t               ptr;
    ch_t               gnt;
    ch_t               idx;
    logic              found;
    logic              load_en;

    assign y_vec   = {y3, y2, y1, y0};
    assign ch      = ch_from_sel(sel1, sel0);
    // Any high output on a channel other than the selected one is a protocol error.
    assign stray   = |(y_vec & ~ch_onehot(ch));
    assign smp_ok  = in_vld && !stray;
    assign load_en = !out_vld || out_rdy;

    genvar k;
    generate
        for (k = 0; k < CH_NUM; k++) begin : g_lane
            collector_lane #(.WIDTH(WIDTH)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .smp    (smp_ok && (ch == ch_t'(k))),
                .bit_in (y_vec[k]),
                .drain  (drain_vec[k]),
                .hold   (hold_w[k]),
                .hold_v (hold_v_vec[k]),
                .ovf    (ovf[k])
            );
        end
    endgenerate

    // Round-robin search for the first holding lane starting at ptr
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            idx = ptr + ch_t'(i);
            if (!found && hold_v_vec[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign drain_vec = (load_en && found) ? ch_onehot(gnt) : '0;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (load_en) begin
            if (found) begin
                out_vld  <= 1'b1;
                out_data <= hold_w[gnt];
                out_ch   <= gnt;
                ptr      <= gnt + 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else if (in_vld && stray) begin
            perr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_1_4_collector.sv
// Directed bench for demux_1_4_collector with a queue-based reference model.
module tb_demux_1_4_collector;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_vld;
    logic             sel0, sel1;
    logic [3:0]       ybus;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_ch;
    logic [3:0]       ovf;
    logic             perr;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    demux_1_4_collector #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .sel0     (sel0),
        .sel1     (sel1),
        .y0       (ybus[0]),
        .y1       (ybus[1]),
        .y2       (ybus[2]),
        .y3       (ybus[3]),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ch   (out_ch),
        .ovf      (ovf),
        .perr     (perr)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel bit count and accumulated value, one
    // pending slot per channel, one output slot, and a delivered-word log.
    int         m_n    [4];
    int         m_acc  [4];
    int         m_pend [4];
    bit         m_has  [4];
    logic [3:0] m_ovf;
    bit         m_perr;
    bit         m_ov;
    int         m_od;
    int         m_och;
    int         m_ptr;
    int         mc;
    bit         granted;
    int         log_data [$];
    int         log_ch   [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_n[i] = 0; m_acc[i] = 0; m_pend[i] = 0; m_has[i] = 0;
            end
            m_ovf = '0; m_perr = 0; m_ov = 0; m_od = 0; m_och = 0; m_ptr = 0;
        end else begin
            // consumer takes the current word
            if (m_ov && out_rdy) begin
                log_data.push_back(m_od);
                log_ch.push_back(m_och);
                m_ov = 0;
            end
            // an empty output slot takes the next pending word in rotation
            if (!m_ov) begin
                granted = 0;
                for (int i = 0; i < 4; i++) begin
                    mc = (m_ptr + i) % 4;
                    if (!granted && m_has[mc]) begin
                        granted   = 1;
                        m_ov      = 1;
                        m_od      = m_pend[mc];
                        m_och     = mc;
                        m_has[mc] = 0;
                        m_ptr     = (mc + 1) % 4;
                    end
                end
            end
            // new sample
            if (in_vld) begin
                mc = {sel1, sel0};
                if ((ybus & ~(4'b0001 << mc)) != 4'b0000) begin
                    m_perr = 1;
                end else begin
                    m_acc[mc] = m_acc[mc] + (int'(ybus[mc]) << m_n[mc]);
                    m_n[mc]   = m_n[mc] + 1;
                    if (m_n[mc] == WIDTH) begin
                        if (m_has[mc]) begin
                            m_ovf[mc] = 1'b1;
                        end else begin
                            m_has[mc]  = 1;
                            m_pend[mc] = m_acc[mc];
                        end
                        m_acc[mc] = 0;
                        m_n[mc]   = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_vld", int'(out_vld), int'(m_ov));
            if (m_ov) begin
                chk("out_data", int'(out_data), m_od);
                chk("out_ch", int'(out_ch), m_och);
            end
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("perr", int'(perr), int'(m_perr));
        end
    end

    task automatic idle(input int n);
        in_vld = 0;
        ybus   = 4'b0000;
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_raw(input int c, input logic [3:0] yv);
        sel1   = c[1];
        sel0   = c[0];
        ybus   = yv;
        in_vld = 1;
        @(negedge clk);
    endtask

    task automatic strobe(input int c, input logic b);
        strobe_raw(c, b ? (4'b0001 << c) : 4'b0000);
    endtask

    task automatic send_word(input int c, input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) strobe(c, w[i]);
    endtask

    task automatic chk_log(input int idx, input int data, input int ch);
        if (idx < log_data.size()) begin
            chk("log_data", log_data[idx], data);
            chk("log_ch", log_ch[idx], ch);
        end else begin
            chk("log_present", log_data.size(), idx + 1);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] w96;
        rst_n   = 0;
        in_vld  = 0;
        sel0    = 0;
        sel1    = 0;
        ybus    = 4'b0000;
        out_rdy = 1;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("rst_out_vld", int'(out_vld), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_perr", int'(perr), 0);
        rst_n = 1;
        idle(1);

        // single word on ch2, visible one edge after the last bit
        send_word(2, 8'h4D);
        idle(1);
        chk("s1_out_vld", int'(out_vld), 1);
        chk("s1_out_ch", int'(out_ch), 2);
        chk("s1_out_data", int'(out_data), 8'h4D);
        idle(2);
        chk_log(0, 8'h4D, 2);

        // interleaved ch0 ones / ch3 zeros
        for (int i = 0; i < WIDTH; i++) begin
            strobe(0, 1'b1);
            strobe(3, 1'b0);
        end
        idle(4);
        chk("s2_log_size", log_data.size(), 3);
        chk_log(1, 8'hFF, 0);
        chk_log(2, 8'h00, 3);
        chk("s2_ovf", int'(ovf), 0);

        // back-pressure: third word on ch1 is dropped
        out_rdy = 0;
        send_word(1, 8'hA1);
        send_word(1, 8'h5B);
        send_word(1, 8'h3C);
        idle(2);
        chk("s3_out_vld", int'(out_vld), 1);
        chk("s3_out_data", int'(out_data), 8'hA1);
        chk("s3_out_ch", int'(out_ch), 1);
        chk("s3_ovf", int'(ovf), 4'b0010);
        out_rdy = 1;
        idle(4);
        chk("s3_log_size", log_data.size(), 5);
        chk_log(3, 8'hA1, 1);
        chk_log(4, 8'h5B, 1);

        // several lanes holding at once, released together
        out_rdy = 0;
        send_word(2, 8'h21);
        send_word(0, 8'h02);
        send_word(1, 8'h13);
        send_word(3, 8'h34);
        send_word(2, 8'h25);
        idle(2);
        out_rdy = 1;
        idle(7);
        chk("s4_log_size", log_data.size(), 10);
        chk_log(5, 8'h21, 2);
        chk_log(6, 8'h34, 3);
        chk_log(7, 8'h02, 0);
        chk_log(8, 8'h13, 1);
        chk_log(9, 8'h25, 2);

        // stray high on ch3 while ch1 selected, in the middle of a ch1 word
        w96 = 8'h96;
        for (int i = 0; i < 3; i++) strobe(1, w96[i]);
        strobe_raw(1, 4'b1000);
        idle(1);
        chk("s5_perr", int'(perr), 1);
        for (int i = 3; i < WIDTH; i++) strobe(1, w96[i]);
        idle(3);
        chk("s5_log_size", log_data.size(), 11);
        chk_log(10, 8'h96, 1);

        // reset in the middle of a ch0 word
        for (int i = 0; i < 5; i++) strobe(0, 1'b1);
        in_vld = 0;
        ybus   = 4'b0000;
        rst_n  = 0;
        @(negedge clk);
        chk("s6_out_vld", int'(out_vld), 0);
        chk("s6_out_data", int'(out_data), 0);
        chk("s6_ovf", int'(ovf), 0);
        chk("s6_perr", int'(perr), 0);
        rst_n = 1;
        send_word(0, 8'h3A);
        idle(3);
        chk("s6_log_size", log_data.size(), 12);
        chk_log(11, 8'h3A, 0);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
